pu_id_gpr_file_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the PU decode stage. It generalises the 2-read/1-write GPR in width, depth and read-port count, and adds:
- a second write port;
- an optional hardwired zero register;
- a sequential clear engine, so the array carries no reset and can map to distributed RAM;
- a per-register pending-write scoreboard for hazard detection.

---
 rtl/pu_id_gpr_file_mp_pkg.sv | 13 +
 rtl/pu_id_gpr_file_mp_if.sv | 32 +++
 rtl/pu_id_gpr_file_mp_sb.sv | 38 +++
 rtl/pu_id_gpr_file_mp.sv | 86 ++++++++
 tb/tb_pu_id_gpr_file_mp.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/pu_id_gpr_file_mp_pkg.sv
// pu_id_gpr_file_mp_pkg: sizes and FSM encodings shared by the multi-port GPR file.
package pu_id_gpr_file_mp_pkg;
   localparam int PU_GPR_NUM    = 32;
   localparam int PU_GPR_ADDR_W = 5;
   localparam int WORD_W        = 32;
   localparam int PU_GPR_ST_W   = 1;
   typedef logic [PU_GPR_ADDR_W-1:0] pu_gpr_addr_bus_t;
   typedef logic [WORD_W-1:0]        word_data_bus_t;
   typedef enum logic [PU_GPR_ST_W-1:0] {
      PU_GPR_ST_INIT = 1'b0,
      PU_GPR_ST_RUN  = 1'b1
   } pu_gpr_state_e;
endpackage

// File: rtl/pu_id_gpr_file_mp_if.sv
// pu_id_gpr_file_mp_if: read, write, scoreboard and control bundle of the GPR file.
interface pu_id_gpr_file_mp_if
   import pu_id_gpr_file_mp_pkg::*;
#(
   parameter int DATA_W = WORD_W,
   parameter int ADDR_W = PU_GPR_ADDR_W,
   parameter int NUM_RD = 2
);
   logic                     init_req;
   logic                     ready;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr0_en;
   logic [ADDR_W-1:0]        wr0_addr;
   logic [DATA_W-1:0]        wr0_data;
   logic                     wr1_en;
   logic [ADDR_W-1:0]        wr1_addr;
   logic [DATA_W-1:0]        wr1_data;
   logic                     sb_set_en;
   logic [ADDR_W-1:0]        sb_set_addr;
   modport master (
      output init_req, rd_addr, wr0_en, wr0_addr, wr0_data,
             wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr,
      input  ready, rd_data, rd_busy
   );
   modport slave (
      input  init_req, rd_addr, wr0_en, wr0_addr, wr0_data,
             wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr,
      output ready, rd_data, rd_busy
   );
endinterface

// File: rtl/pu_id_gpr_file_mp_sb.sv
// pu_id_gpr_file_mp_sb: per-register pending-write bits; a same-cycle set beats a clear.
module pu_id_gpr_file_mp_sb
   import pu_id_gpr_file_mp_pkg::*;
#(
   parameter int DEPTH    = PU_GPR_NUM,
   parameter int ADDR_W   = PU_GPR_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_,
   input  logic                     clr_i,
   input  logic                     wr0_en_i,
   input  logic [ADDR_W-1:0]        wr0_addr_i,
   input  logic                     wr1_en_i,
   input  logic [ADDR_W-1:0]        wr1_addr_i,
   input  logic                     set_en_i,
   input  logic [ADDR_W-1:0]        set_addr_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD-1:0]        busy_o
);
   logic [DEPTH-1:0] sb_q, sb_d;
   always_comb begin
      sb_d = sb_q;
      if (wr0_en_i) sb_d[wr0_addr_i] = 1'b0;
      if (wr1_en_i) sb_d[wr1_addr_i] = 1'b0;
      if (set_en_i) sb_d[set_addr_i] = 1'b1;
      if (clr_i) sb_d = '0;
      if (ZERO_REG != 0) sb_d[0] = 1'b0;
   end
   always_ff @(posedge clk or negedge rst_)
      if (!rst_) sb_q <= '0;
      else sb_q <= sb_d;
   genvar k;
   for (k = 0; k < NUM_RD; k++) begin : g_rd
      assign busy_o[k] = sb_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
   end
endmodule

// File: rtl/pu_id_gpr_file_mp.sv
// pu_id_gpr_file_mp: multi-port GPR file with sequential clear and hazard scoreboard.
// Define PU_GPR_BYPASS_EN to forward same-cycle write data to the read ports.
module pu_id_gpr_file_mp
   import pu_id_gpr_file_mp_pkg::*;
#(
   parameter int DATA_W   = WORD_W,
   parameter int DEPTH    = PU_GPR_NUM,
   parameter int ADDR_W   = PU_GPR_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input logic                 clk,
   input logic                 rst_,
   pu_id_gpr_file_mp_if.slave  gpr
);
   pu_gpr_state_e     state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [NUM_RD-1:0] sb_busy;
   logic              run, we0, we1, set;
   assign run = state_q == PU_GPR_ST_RUN;
   assign we0 = run && gpr.wr0_en && !(ZERO_REG != 0 && gpr.wr0_addr == '0);
   assign we1 = run && gpr.wr1_en && !(ZERO_REG != 0 && gpr.wr1_addr == '0);
   assign set = run && gpr.sb_set_en;
   assign gpr.ready = run;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!run) begin
         cnt_d   = cnt_q + 1'b1;
         state_d = cnt_q == ADDR_W'(DEPTH - 1) ? PU_GPR_ST_RUN : PU_GPR_ST_INIT;
      end else if (gpr.init_req) begin
         cnt_d   = '0;
         state_d = PU_GPR_ST_INIT;
      end
   end
   always_ff @(posedge clk or negedge rst_)
      if (!rst_) begin
         state_q <= PU_GPR_ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   // No reset on the array so it can map to distributed RAM; INIT zeroes it instead.
   always_ff @(posedge clk)
      if (!run) mem_q[cnt_q] <= '0;
      else begin
         if (we0) mem_q[gpr.wr0_addr] <= gpr.wr0_data;
         if (we1) mem_q[gpr.wr1_addr] <= gpr.wr1_data;
      end
   pu_id_gpr_file_mp_sb #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .rst_       (rst_),
      .clr_i      (run && gpr.init_req),
      .wr0_en_i   (we0),
      .wr0_addr_i (gpr.wr0_addr),
      .wr1_en_i   (we1),
      .wr1_addr_i (gpr.wr1_addr),
      .set_en_i   (set),
      .set_addr_i (gpr.sb_set_addr),
      .rd_addr_i  (gpr.rd_addr),
      .busy_o     (sb_busy)
   );
   genvar k;
   for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] raw;
      logic              byp;
      assign a = gpr.rd_addr[k*ADDR_W +: ADDR_W];
`ifdef PU_GPR_BYPASS_EN
      logic hit0, hit1;
      assign hit0 = we0 && gpr.wr0_addr == a;
      assign hit1 = we1 && gpr.wr1_addr == a;
      assign byp  = hit0 || hit1;
      assign raw  = hit1 ? gpr.wr1_data : hit0 ? gpr.wr0_data : mem_q[a];
`else
      assign byp = 1'b0;
      assign raw = mem_q[a];
`endif
      assign gpr.rd_data[k*DATA_W +: DATA_W] = (run && !(ZERO_REG != 0 && a == '0)) ? raw : '0;
      assign gpr.rd_busy[k] = run && sb_busy[k] && !byp;
   end
endmodule

// File: tb/tb_pu_id_gpr_file_mp.sv
// tb_pu_id_gpr_file_mp: vector table plus hand sequences for INIT timing, bypass and restart.
module tb_pu_id_gpr_file_mp;
   logic clk = 1'b0;
   logic rst_ = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   pu_id_gpr_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) gif ();
   pu_id_gpr_file_mp #(
      .DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
   ) dut (
      .clk  (clk),
      .rst_ (rst_),
      .gpr  (gif)
   );
   typedef struct {
      logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
      logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
      logic        se;  logic [4:0] sa;
      logic [4:0]  r0;  logic [4:0] r1;
      logic [31:0] e0;  logic [31:0] e1; logic [1:0] eb;
   } vec_t;
   typedef struct {
      string       nm;
      logic [31:0] d0, d1;
      logic [1:0]  b;
   } exp_t;
   exp_t sbq[$];
   vec_t tbl[12];
`ifdef PU_GPR_BYPASS_EN
   localparam logic [31:0] BYP_D = 32'h1234_5678;
   localparam logic [1:0]  BYP_B = 2'b00;
`else
   localparam logic [31:0] BYP_D = 32'h0;
   localparam logic [1:0]  BYP_B = 2'b11;
`endif
   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic drive(vec_t v);
      gif.wr0_en = v.w0e; gif.wr0_addr = v.w0a; gif.wr0_data = v.w0d;
      gif.wr1_en = v.w1e; gif.wr1_addr = v.w1a; gif.wr1_data = v.w1d;
      gif.sb_set_en = v.se; gif.sb_set_addr = v.sa;
      gif.rd_addr = {v.r1, v.r0};
   endtask
   // Drive one cycle, queue its expectation, check it mid-cycle, then advance past the edge.
   task automatic run_vec(string nm, vec_t v);
      exp_t e;
      drive(v);
      sbq.push_back('{nm, v.e0, v.e1, v.eb});
      @(negedge clk);
      e = sbq.pop_front();
      cmp({e.nm, " d0"}, gif.rd_data[31:0], e.d0);
      cmp({e.nm, " d1"}, gif.rd_data[63:32], e.d1);
      cmp({e.nm, " busy"}, 32'(gif.rd_busy), 32'(e.b));
      cmp({e.nm, " ready"}, 32'(gif.ready), 32'd1);
      @(posedge clk);
      #1;
   endtask
   task automatic count_init(string nm, logic chk_rd);
      int n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (gif.ready) break;
         if (chk_rd) begin
            cmp({nm, " init rd"}, gif.rd_data[31:0], 32'h0);
            cmp({nm, " init busy"}, 32'(gif.rd_busy), 32'h0);
         end
      end
      cmp({nm, " init cycles"}, n, 32);
   endtask
   initial begin
      vec_t v;
      tbl[0]  = '{1, 5, 32'hAAAA_0000, 1, 5, 32'h5555_1234, 0, 0, 1, 2, 32'h0, 32'h0, 2'b00};
      tbl[1]  = '{1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0, 1, 0, 5, 5, 32'h5555_1234, 32'h5555_1234, 2'b00};
      tbl[2]  = '{0, 0, 32'h0, 0, 0, 32'h0, 1, 7, 0, 0, 32'h0, 32'h0, 2'b00};
      tbl[3]  = '{1, 7, 32'h1111_0007, 0, 0, 32'h0, 1, 7, 5, 0, 32'h5555_1234, 32'h0, 2'b00};
      tbl[4]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 7, 5, 32'h1111_0007, 32'h5555_1234, 2'b01};
      tbl[5]  = '{0, 0, 32'h0, 1, 7, 32'h2222_0007, 0, 0, 5, 0, 32'h5555_1234, 32'h0, 2'b00};
      tbl[6]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 7, 7, 32'h2222_0007, 32'h2222_0007, 2'b00};
      tbl[7]  = '{1, 10, 32'h0A0A_0A0A, 1, 11, 32'h0B0B_0B0B, 1, 12, 1, 2, 32'h0, 32'h0, 2'b00};
      tbl[8]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 10, 11, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 2'b00};
      tbl[9]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 12, 10, 32'h0, 32'h0A0A_0A0A, 2'b01};
      tbl[10] = '{0, 0, 32'h0, 1, 12, 32'h0000_CCCC, 0, 0, 11, 11, 32'h0B0B_0B0B, 32'h0B0B_0B0B, 2'b00};
      tbl[11] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 12, 12, 32'h0000_CCCC, 32'h0000_CCCC, 2'b00};
      gif.init_req = 1'b0;
      v = '{1, 4, 32'hFF, 0, 0, 32'h0, 1, 4, 4, 4, 32'h0, 32'h0, 2'b00};
      drive(v);
      repeat (3) @(posedge clk);
      #1;
      cmp("reset ready", 32'(gif.ready), 32'h0);
      cmp("reset busy", 32'(gif.rd_busy), 32'h0);
      rst_ = 1'b1;
      count_init("boot", 1'b1);
      v = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00};
      drive(v);
      for (int a = 0; a < 32; a += 2) begin
         gif.rd_addr = {5'(a + 1), 5'(a)};
         #1;
         cmp($sformatf("clear rd %0d", a), gif.rd_data[31:0], 32'h0);
         cmp($sformatf("clear rd %0d", a + 1), gif.rd_data[63:32], 32'h0);
         cmp($sformatf("clear busy %0d", a), 32'(gif.rd_busy), 32'h0);
      end
      for (int i = 0; i < 12; i++) run_vec($sformatf("row%0d", i), tbl[i]);
      v = '{0, 0, 32'h0, 0, 0, 32'h0, 1, 3, 0, 0, 32'h0, 32'h0, 2'b00};
      run_vec("byp set", v);
      v = '{1, 3, 32'h1234_5678, 0, 0, 32'h0, 0, 0, 3, 3, BYP_D, BYP_D, BYP_B};
      run_vec("byp same", v);
      v = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 3, 3, 32'h1234_5678, 32'h1234_5678, 2'b00};
      run_vec("byp next", v);
      v = '{1, 9, 32'h0000_0099, 0, 0, 32'h0, 1, 9, 0, 0, 32'h0, 32'h0, 2'b00};
      run_vec("r9 wr", v);
      v = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 9, 9, 32'h0000_0099, 32'h0000_0099, 2'b11};
      gif.init_req = 1'b1;
      run_vec("r9 init", v);
      gif.init_req = 1'b0;
      cmp("init_req ready drop", 32'(gif.ready), 32'h0);
      count_init("restart", 1'b1);
      #1;
      cmp("r9 cleared", gif.rd_data[31:0], 32'h0);
      cmp("r9 not busy", 32'(gif.rd_busy), 32'h0);
      v = '{1, 6, 32'h66, 0, 0, 32'h0, 1, 6, 1, 2, 32'h0, 32'h0, 2'b00};
      run_vec("r6 wr", v);
      v = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 6, 6, 32'h66, 32'h66, 2'b11};
      drive(v);
      #2;
      rst_ = 1'b0;
      #1;
      cmp("async rst ready", 32'(gif.ready), 32'h0);
      cmp("async rst busy", 32'(gif.rd_busy), 32'h0);
      @(posedge clk);
      #1;
      rst_ = 1'b1;
      count_init("rerst", 1'b0);
      #1;
      cmp("r6 cleared", gif.rd_data[31:0], 32'h0);
      cmp("r6 not busy", 32'(gif.rd_busy), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
